// File: rtl/aes128_inv_key_scheduler.sv
// AES-128 key schedule for the decryption datapath.
// The forward expansion runs one round per cycle until round key 10 is reached. The keys are
// then streamed in reverse order (10 down to 0), and each earlier key is rebuilt from the
// current one by the inverse recurrence, so no key store is needed.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   start       one-cycle request that samples cipher_key; honoured only when idle
//   cipher_key  128-bit key, bits 127:96 are word w0
//   busy        high whenever the scheduler is not idle
//   key_valid   round_key/round_idx are valid
//   key_ready   consumer accepts the current key
//   round_key   current round key, same word order as cipher_key
//   round_idx   index of round_key, 10 first, 0 last
//   done        one-cycle pulse after round key 0 has been accepted
module aes128_inv_key_scheduler #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         done
);

  localparam logic [3:0] LastStep = 4'(NR - 1);
  localparam logic [3:0] LastIdx  = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {StIdle, StFwd, StOut} state_e;

  state_e       state_q, state_d;
  logic [127:0] cur_q, cur_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_src, rot, g;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;
  logic [7:0]  rcon_fwd, rcon_inv;

  assign w0 = cur_q[127:96];
  assign w1 = cur_q[95:64];
  assign w2 = cur_q[63:32];
  assign w3 = cur_q[31:0];

  // One S-box word shared by both directions: the forward step substitutes w3, the inverse step
  // substitutes the recovered previous w3 (= w3 ^ w2).
  assign p3      = w3 ^ w2;
  assign sub_src = (state_q == StOut) ? p3 : w3;
  assign rot     = {sub_src[23:0], sub_src[31:24]};
  assign g       = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
                   ^ {rcon_q, 24'h0};

  assign n0 = w0 ^ g;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ g;

  assign rcon_fwd = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Undo xtime: only the two values produced by the 0x1b reduction need special handling.
  always_comb begin
    rcon_inv = rcon_q >> 1;
    if (rcon_q == 8'h1b) begin
      rcon_inv = 8'h80;
    end else if (rcon_q == 8'h36) begin
      rcon_inv = 8'h1b;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = cipher_key;
          cnt_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = StFwd;
        end
      end
      StFwd: begin
        cur_d = {n0, n1, n2, n3};
        if (cnt_q == LastStep) begin
          // rcon is left at the last round's value so the inverse walk can start from it.
          idx_d   = LastIdx;
          state_d = StOut;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          rcon_d = rcon_fwd;
        end
      end
      StOut: begin
        if (key_ready) begin
          if (idx_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cur_d  = {p0, p1, p2, p3};
            idx_d  = idx_q - 4'd1;
            rcon_d = rcon_inv;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign key_valid = (state_q == StOut);
  assign round_key = cur_q;
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes128_inv_key_scheduler.sv
// Self-checking bench for aes128_inv_key_scheduler: FIPS-197 and all-zero keys, latency,
// backpressure stability, ignored start requests, mid-run resets and back-to-back runs.
module tb_aes128_inv_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;

  aes128_inv_key_scheduler #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           pos;
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AltKey  = 128'hdeadbeef0123456789abcdeffedcba98;

  vec_t fips_tbl[11];
  vec_t zero_tbl[3];

  int checks = 0;
  int errors = 0;

  logic [127:0] got_key[$];
  logic [3:0]   got_idx[$];
  int           first_valid_cyc;
  int           done_cyc;
  int           done_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"}, 128'(busy), 128'd0);
    chk({tag, " key_valid"}, 128'(key_valid), 128'd0);
    chk({tag, " round_key"}, round_key, 128'd0);
    chk({tag, " round_idx"}, 128'(round_idx), 128'd0);
    chk({tag, " done"}, 128'(done), 128'd0);
  endtask

  // Drives one run and records every transfer. Cycle numbers count negedges after the cycle in
  // which start is sampled. inj_a/inj_b raise start with AltKey on those cycles. With b2b_en the
  // task raises start (b2b_key) in the done cycle and returns; skip_start continues such a run.
  task automatic run(input logic [127:0] key, input bit bp, input int inj_a, input int inj_b,
                     input bit skip_start, input bit b2b_en, input logic [127:0] b2b_key);
    bit           prev_stall;
    bit           finished;
    logic [127:0] pk;
    logic [3:0]   pi;
    got_key.delete();
    got_idx.delete();
    first_valid_cyc = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    prev_stall      = 1'b0;
    finished        = 1'b0;
    pk              = '0;
    pi              = '0;
    if (!skip_start) begin
      @(negedge clk);
      start      = 1'b1;
      cipher_key = key;
      key_ready  = 1'b1;
    end
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      start      = (cyc == inj_a) || (cyc == inj_b);
      cipher_key = start ? AltKey : key;
      if (prev_stall) begin
        chk("stall stability", {round_idx, round_key}, {pi, pk});
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (b2b_en && done) begin
        start      = 1'b1;
        cipher_key = b2b_key;
        finished   = 1'b1;
      end else begin
        if (key_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (got_idx.size() == 11 && !key_valid && !done) finished = 1'b1;
        key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (key_valid && key_ready) begin
          got_key.push_back(round_key);
          got_idx.push_back(round_idx);
        end
        prev_stall = key_valid && !key_ready;
        pk         = round_key;
        pi         = round_idx;
      end
    end
    if (!b2b_en) start = 1'b0;
    if (!finished) begin
      errors++;
      checks++;
      $display("FAIL run timeout: got %0d transfers expected 11", got_idx.size());
    end
  endtask

  task automatic verify(input bit zero, input string tag);
    chk({tag, " transfer count"}, 128'(got_idx.size()), 128'd11);
    chk({tag, " done pulses"}, 128'(done_cnt), 128'd1);
    if (got_idx.size() == 11) begin
      for (int i = 0; i < 11; i++) begin
        chk({tag, " idx order"}, 128'(got_idx[i]), 128'(10 - i));
      end
      if (zero) begin
        for (int i = 0; i < 3; i++) begin
          chk({tag, " zero key"}, got_key[zero_tbl[i].pos], zero_tbl[i].key);
        end
      end else begin
        for (int i = 0; i < 11; i++) begin
          chk({tag, " fips key"}, got_key[fips_tbl[i].pos], fips_tbl[i].key);
        end
      end
    end
  endtask

  task automatic chk_timing(input string tag);
    chk({tag, " first valid cycle"}, 128'(first_valid_cyc), 128'd11);
    chk({tag, " done cycle"}, 128'(done_cyc), 128'd22);
  endtask

  initial begin
    bit hit;
    fips_tbl[0]  = '{10, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    fips_tbl[1]  = '{9,  4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_tbl[2]  = '{8,  4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips_tbl[3]  = '{7,  4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips_tbl[4]  = '{6,  4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips_tbl[5]  = '{5,  4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips_tbl[6]  = '{4,  4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips_tbl[7]  = '{3,  4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips_tbl[8]  = '{2,  4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips_tbl[9]  = '{1,  4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips_tbl[10] = '{0,  4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    zero_tbl[0]  = '{0,  4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    zero_tbl[1]  = '{9,  4'd1,  128'h62636363626363636263636362636363};
    zero_tbl[2]  = '{10, 4'd0,  128'h0};

    rst        = 1'b1;
    start      = 1'b0;
    key_ready  = 1'b0;
    cipher_key = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("initial reset");
    rst = 1'b0;
    @(negedge clk);

    run(FipsKey, 1'b0, -1, -1, 1'b0, 1'b0, '0);
    verify(1'b0, "fips");
    chk_timing("fips");

    run(128'h0, 1'b0, -1, -1, 1'b0, 1'b0, '0);
    verify(1'b1, "zero");
    chk_timing("zero");

    run(FipsKey, 1'b1, -1, -1, 1'b0, 1'b0, '0);
    verify(1'b0, "backpressure");

    // start during FWD (cycle 5) and OUT (cycle 14) must be ignored
    run(FipsKey, 1'b1, 5, 14, 1'b0, 1'b0, '0);
    verify(1'b0, "ignored start");
    run(128'h0, 1'b0, -1, -1, 1'b0, 1'b0, '0);
    verify(1'b1, "start after done");

    // reset in FWD cycle 5
    @(negedge clk);
    start      = 1'b1;
    cipher_key = FipsKey;
    key_ready  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset in fwd");
    hit = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) hit = 1'b1;
    end
    chk("no activity after fwd reset", 128'(hit), 128'd0);

    // reset in OUT at idx 6
    @(negedge clk);
    start      = 1'b1;
    cipher_key = FipsKey;
    hit        = 1'b0;
    for (int c = 1; c <= 40 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (key_valid && round_idx == 4'd6) begin
        rst = 1'b1;
        hit = 1'b1;
      end
    end
    chk("reached idx 6", 128'(hit), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset in out");
    hit = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) hit = 1'b1;
    end
    chk("no activity after out reset", 128'(hit), 128'd0);

    run(FipsKey, 1'b0, -1, -1, 1'b0, 1'b0, '0);
    verify(1'b0, "fips after reset");
    chk_timing("fips after reset");

    // back-to-back: zero-key start issued in the done cycle
    run(FipsKey, 1'b0, -1, -1, 1'b0, 1'b1, 128'h0);
    verify(1'b0, "b2b first");
    run(128'h0, 1'b0, -1, -1, 1'b1, 1'b0, '0);
    verify(1'b1, "b2b second");
    chk_timing("b2b second");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
